speed_meas_ctrl: RTL

SPEED_MEAS_CTRL -- requirements
Module: speed_meas_ctrl

---
 rtl/speed_meas_pkg.sv | 26 ++
 rtl/hall_edge_counter.sv | 59 +++++
 rtl/speed_meas_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/speed_meas_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : speed_meas_pkg
//  Description : Shared types and constants for the hall-sensor speed
//                measurement controller: FSM state encoding, default counter
//                width and the minimum gate window length.
//  Revision    : 1.0 - initial release
// ============================================================================
package speed_meas_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        LATCH = 2'd3
    } state_t;

    // Default width of gate timer, edge counter and result
    localparam int CNT_W_DEF = 32;

    // Shortest gate window; smaller requests are rounded up to this
    localparam int MIN_GATE = 2;

endpackage : speed_meas_pkg
`default_nettype wire

// File: rtl/hall_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module      : hall_edge_counter
//  Description : Synchronizes the raw hall-sensor signal into the clk domain,
//                detects rising edges and counts them in a saturating counter
//                with synchronous clear and count enable.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk       in   system clock
//    rst       in   synchronous active-high reset
//    i_signal  in   raw sensor input, asynchronous to clk
//    i_clr     in   clear the counter (priority over i_en)
//    i_en      in   count detected rising edges while high
//    o_count   out  current edge count, saturates at all-ones
// ============================================================================
module hall_edge_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_signal,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sync3;
    logic [CNT_W-1:0] r_count;
    logic             w_rise;

    // r_sync1/r_sync2 form the metastability synchronizer; r_sync3 is the
    // one-cycle delayed copy used only for edge detection.
    assign w_rise = r_sync2 & ~r_sync3;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= i_signal;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            if (i_clr) begin
                r_count <= '0;
            end else if (i_en && w_rise && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign o_count = r_count;

endmodule : hall_edge_counter
`default_nettype wire

// File: rtl/speed_meas_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : speed_meas_ctrl
//  Description : Hall-sensor speed measurement controller. Counts rising
//                edges of the sensor signal over a programmable gate window,
//                single-shot or back-to-back, and presents the result with a
//                valid/ack handshake, a sticky overrun flag and an optional
//                motor-stall detector.
//  Revision    : 1.0 - initial release
//
//  Build option
//    SPEED_MEAS_STALL_EN  when defined, stall is raised after STALL_WINDOWS
//                         consecutive zero-edge windows; otherwise stall is 0.
//
//  Ports
//    clk          in   system clock (rising edge)
//    reset        in   synchronous active-high reset
//    signal       in   raw hall-sensor output, asynchronous
//    start        in   single-cycle measurement request (ignored when busy)
//    continuous   in   repeat windows back-to-back while high
//    gate_cycles  in   window length in clk cycles, sampled in ARM
//    edge_count   out  edge count of the last completed window
//    count_valid  out  edge_count holds unacknowledged data
//    count_ack    in   consumer acknowledge of count_valid
//    busy         out  controller is not IDLE
//    overrun      out  sticky: a result was overwritten before ack
//    stall        out  motor-stall flag
// ============================================================================
module speed_meas_ctrl
    import speed_meas_pkg::*;
#(
    parameter int CLK_HZ        = 100_000_000,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int STALL_WINDOWS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             signal,
    input  logic             start,
    input  logic             continuous,
    input  logic [CNT_W-1:0] gate_cycles,
    output logic [CNT_W-1:0] edge_count,
    output logic             count_valid,
    input  logic             count_ack,
    output logic             busy,
    output logic             overrun,
    output logic             stall
);

    // Elaboration-time parameter sanity checks
    if (CLK_HZ <= 0) begin : g_bad_clk_hz
        $error("speed_meas_ctrl: CLK_HZ must be positive");
    end
    if (CNT_W < 2) begin : g_bad_cnt_w
        $error("speed_meas_ctrl: CNT_W must be at least 2");
    end
    if (STALL_WINDOWS < 1) begin : g_bad_stall_windows
        $error("speed_meas_ctrl: STALL_WINDOWS must be at least 1");
    end

    localparam logic [CNT_W-1:0] c_MIN_GATE = CNT_W'(MIN_GATE);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] r_gate_len;
    logic [CNT_W-1:0] r_edge_count;
    logic             r_count_valid;
    logic             r_overrun;
    logic [CNT_W-1:0] w_gate_len;
    logic [CNT_W-1:0] w_cnt;
    logic             w_gate_done;
    logic             w_clr;
    logic             w_en;
    logic             w_latch;
    logic             w_begin;

    // ------------------------------------------------------------------
    // Edge synchronizer / counter
    // ------------------------------------------------------------------
    hall_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge_cnt (
        .clk      (clk),
        .rst      (reset),
        .i_signal (signal),
        .i_clr    (w_clr),
        .i_en     (w_en),
        .o_count  (w_cnt)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_gate_done = (r_timer == (r_gate_len - CNT_W'(1)));

    always_comb begin
        w_state_nxt = r_state;
        w_clr       = 1'b0;
        w_en        = 1'b0;
        w_latch     = 1'b0;
        w_begin     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = ARM;
                    w_begin     = 1'b1;
                end
            end
            ARM: begin
                w_clr       = 1'b1;
                w_state_nxt = COUNT;
            end
            COUNT: begin
                // Enabled through the final cycle so an edge there is counted
                w_en = 1'b1;
                if (w_gate_done) begin
                    w_state_nxt = LATCH;
                end
            end
            LATCH: begin
                w_latch     = 1'b1;
                w_state_nxt = continuous ? ARM : IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Gate timer; window length is clamped to MIN_GATE when sampled
    // ------------------------------------------------------------------
    assign w_gate_len = (gate_cycles < c_MIN_GATE) ? c_MIN_GATE : gate_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer    <= '0;
            r_gate_len <= '0;
        end else if (r_state == ARM) begin
            r_timer    <= '0;
            r_gate_len <= w_gate_len;
        end else if (r_state == COUNT) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Result register and handshake. A LATCH update always leaves data
    // valid; an ack in the same cycle is consumed by the old data, so it
    // neither clears valid nor counts as an overwrite.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge_count  <= '0;
            r_count_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (w_latch) begin
                r_edge_count  <= w_cnt;
                r_count_valid <= 1'b1;
                if (r_count_valid && !count_ack) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_count_valid && count_ack) begin
                r_count_valid <= 1'b0;
            end
            if (w_begin) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign edge_count  = r_edge_count;
    assign count_valid = r_count_valid;
    assign overrun     = r_overrun;
    assign busy        = (r_state != IDLE);

    // ------------------------------------------------------------------
    // Stall detector
    // ------------------------------------------------------------------
`ifdef SPEED_MEAS_STALL_EN
    localparam int               c_ZW    = $clog2(STALL_WINDOWS + 1);
    localparam logic [c_ZW-1:0]  c_ZMAX  = c_ZW'(STALL_WINDOWS);
    localparam logic [c_ZW-1:0]  c_ZTRIP = c_ZW'(STALL_WINDOWS - 1);

    logic [c_ZW-1:0] r_zero_win;
    logic            r_stall;

    // r_zero_win counts completed zero-edge windows; stall trips when the
    // window now completing is the STALL_WINDOWS-th in a row.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_zero_win <= '0;
            r_stall    <= 1'b0;
        end else if (w_begin) begin
            r_zero_win <= '0;
            r_stall    <= 1'b0;
        end else if (w_latch) begin
            if (w_cnt == '0) begin
                if (r_zero_win != c_ZMAX) begin
                    r_zero_win <= r_zero_win + 1'b1;
                end
                if (r_zero_win >= c_ZTRIP) begin
                    r_stall <= 1'b1;
                end
            end else begin
                r_zero_win <= '0;
                r_stall    <= 1'b0;
            end
        end
    end

    assign stall = r_stall;
`else
    assign stall = 1'b0;
`endif

endmodule : speed_meas_ctrl
`default_nettype wire
